// File: rtl/calc_key_entry.sv
// Operand-entry controller for the BCD calculator: turns key events into
// registered operands, an operation code and the value shown on the display.
module calc_key_entry #(
  parameter logic [3:0] KEY_ADD = 4'hA,
  parameter logic [3:0] KEY_SUB = 4'hB,
  parameter logic [3:0] KEY_EQ  = 4'hC,
  parameter logic [3:0] KEY_CLR = 4'hD,
  parameter logic [3:0] KEY_BS  = 4'hE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_result,
  output logic [15:0] num1_bcd,
  output logic [15:0] num2_bcd,
  output logic [1:0]  operacion,
  output logic [15:0] display_bcd,
  output logic        result_valid,
  output logic [1:0]  estado
);

  localparam logic [1:0] S_NUM1   = 2'd0;
  localparam logic [1:0] S_OP     = 2'd1;
  localparam logic [1:0] S_NUM2   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  logic [1:0]  state, state_n;
  logic [15:0] num1, num1_n;
  logic [15:0] num2, num2_n;
  logic [1:0]  op, op_n;
  logic [15:0] result, result_n;
  logic [2:0]  count, count_n;
  logic [15:0] display, display_n;
  logic        rv, rv_n;

  logic        is_digit;
  logic        is_op;
  logic [1:0]  key_op;
  logic        digit_take;
  logic [15:0] active;
  logic [15:0] active_shift;
  logic [15:0] active_bs;
  logic [2:0]  count_bs;
  logic [2:0]  first_count;

  // Number of significant digits, used when backing out of S_OP into num1.
  function automatic logic [2:0] sig_digits(input logic [15:0] v);
    if (v[15:12] != 4'h0)     return 3'd4;
    else if (v[11:8] != 4'h0) return 3'd3;
    else if (v[7:4] != 4'h0)  return 3'd2;
    else if (v[3:0] != 4'h0)  return 3'd1;
    else                      return 3'd0;
  endfunction

  always_comb begin
    is_digit     = (key_code <= 4'd9);
    is_op        = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    key_op       = (key_code == KEY_ADD) ? OP_ADD : OP_SUB;
    active       = (state == S_NUM2) ? num2 : num1;
    active_shift = {active[11:0], key_code};
    active_bs    = {4'h0, active[15:4]};
    count_bs     = (count == 3'd0) ? 3'd0 : count - 3'd1;
    // A leading zero is swallowed; a full operand ignores further digits.
    digit_take   = is_digit && (count != 3'd4) &&
                   !((count == 3'd0) && (key_code == 4'h0));
    first_count  = (key_code == 4'h0) ? 3'd0 : 3'd1;
  end

  always_comb begin
    state_n  = state;
    num1_n   = num1;
    num2_n   = num2;
    op_n     = op;
    result_n = result;
    count_n  = count;
    rv_n     = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state_n  = S_NUM1;
        num1_n   = 16'h0;
        num2_n   = 16'h0;
        op_n     = OP_NONE;
        result_n = 16'h0;
        count_n  = 3'd0;
      end else begin
        case (state)
          S_NUM1: begin
            if (digit_take) begin
              num1_n  = active_shift;
              count_n = count + 3'd1;
            end else if (key_code == KEY_BS) begin
              num1_n  = active_bs;
              count_n = count_bs;
            end else if (is_op) begin
              op_n    = key_op;
              num2_n  = 16'h0;
              count_n = 3'd0;
              state_n = S_OP;
            end
          end
          S_OP: begin
            if (is_op) begin
              op_n = key_op;
            end else if (is_digit) begin
              num2_n  = {12'h0, key_code};
              count_n = first_count;
              state_n = S_NUM2;
            end else if (key_code == KEY_BS) begin
              op_n    = OP_NONE;
              count_n = sig_digits(num1);
              state_n = S_NUM1;
            end
          end
          S_NUM2: begin
            if (digit_take) begin
              num2_n  = active_shift;
              count_n = count + 3'd1;
            end else if (key_code == KEY_BS) begin
              num2_n  = active_bs;
              count_n = count_bs;
            end else if (key_code == KEY_EQ) begin
              result_n = alu_result;
              rv_n     = 1'b1;
              state_n  = S_RESULT;
            end else if (is_op) begin
              num1_n  = alu_result;
              num2_n  = 16'h0;
              count_n = 3'd0;
              op_n    = key_op;
              rv_n    = 1'b1;
              state_n = S_OP;
            end
          end
          default: begin
            if (is_digit) begin
              num1_n  = {12'h0, key_code};
              num2_n  = 16'h0;
              op_n    = OP_NONE;
              count_n = first_count;
              state_n = S_NUM1;
            end else if (is_op) begin
              num1_n  = result;
              num2_n  = 16'h0;
              op_n    = key_op;
              count_n = 3'd0;
              state_n = S_OP;
            end
          end
        endcase
      end
    end
  end

  // Display follows the state being entered, so it is chosen from next-state values.
  always_comb begin
    display_n = num1_n;
    case (state_n)
      S_NUM2:   display_n = num2_n;
      S_RESULT: display_n = result_n;
      default:  display_n = num1_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_NUM1;
      num1    <= 16'h0;
      num2    <= 16'h0;
      op      <= OP_NONE;
      result  <= 16'h0;
      count   <= 3'd0;
      display <= 16'h0;
      rv      <= 1'b0;
    end else begin
      state   <= state_n;
      num1    <= num1_n;
      num2    <= num2_n;
      op      <= op_n;
      result  <= result_n;
      count   <= count_n;
      display <= display_n;
      rv      <= rv_n;
    end
  end

  assign num1_bcd     = num1;
  assign num2_bcd     = num2;
  assign operacion    = op;
  assign display_bcd  = display;
  assign result_valid = rv;
  assign estado       = state;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: decimal reference model feeding an expected queue,
// checked by an independent monitor, plus directed value checks.
module tb_calc_key_entry;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hC;
  localparam logic [3:0] K_CLR = 4'hD;
  localparam logic [3:0] K_BS  = 4'hE;
  localparam logic [3:0] K_BAD = 4'hF;

  typedef struct packed {
    logic [15:0] n1;
    logic [15:0] n2;
    logic [1:0]  op;
    logic [15:0] disp;
    logic        rv;
    logic [1:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] alu_result;
  logic [15:0] num1_bcd, num2_bcd, display_bcd;
  logic [1:0]  operacion, estado;
  logic        result_valid;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference state, kept as plain decimal numbers.
  int m_n1, m_n2, m_res, m_st;
  logic [1:0] m_op;
  logic m_rv;

  always #5 clk = ~clk;

  calc_key_entry dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .alu_result(alu_result), .num1_bcd(num1_bcd), .num2_bcd(num2_bcd),
    .operacion(operacion), .display_bcd(display_bcd),
    .result_valid(result_valid), .estado(estado)
  );

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Saturating decimal ALU standing in for the real datapath.
  function automatic int alu_model(input int a, input int b, input logic [1:0] op);
    if (op == 2'b01) return (a + b > 9999) ? 9999 : a + b;
    if (op == 2'b10) return (a >= b) ? a - b : 0;
    return a;
  endfunction

  always_comb alu_result = int2bcd(alu_model(bcd2int(num1_bcd), bcd2int(num2_bcd), operacion));

  task automatic model_reset();
    m_n1 = 0; m_n2 = 0; m_res = 0; m_st = 0; m_op = 2'b00; m_rv = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] k);
    int d;
    logic is_op;
    logic [1:0] kop;
    d = int'(k);
    is_op = (k == K_ADD) || (k == K_SUB);
    kop = (k == K_ADD) ? 2'b01 : 2'b10;
    m_rv = 1'b0;
    if (!v) return;
    if (k == K_CLR) begin
      model_reset();
      return;
    end
    case (m_st)
      0: begin
        if (d <= 9) begin
          if (m_n1 < 1000) m_n1 = m_n1 * 10 + d;
        end else if (k == K_BS) m_n1 = m_n1 / 10;
        else if (is_op) begin
          m_op = kop; m_n2 = 0; m_st = 1;
        end
      end
      1: begin
        if (is_op) m_op = kop;
        else if (d <= 9) begin
          m_n2 = d; m_st = 2;
        end else if (k == K_BS) begin
          m_op = 2'b00; m_st = 0;
        end
      end
      2: begin
        if (d <= 9) begin
          if (m_n2 < 1000) m_n2 = m_n2 * 10 + d;
        end else if (k == K_BS) m_n2 = m_n2 / 10;
        else if (k == K_EQ) begin
          m_res = alu_model(m_n1, m_n2, m_op); m_rv = 1'b1; m_st = 3;
        end else if (is_op) begin
          m_n1 = alu_model(m_n1, m_n2, m_op); m_n2 = 0; m_op = kop;
          m_rv = 1'b1; m_st = 1;
        end
      end
      default: begin
        if (d <= 9) begin
          m_n1 = d; m_n2 = 0; m_op = 2'b00; m_st = 0;
        end else if (is_op) begin
          m_n1 = m_res; m_n2 = 0; m_op = kop; m_st = 1;
        end
      end
    endcase
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.n1 = int2bcd(m_n1);
    e.n2 = int2bcd(m_n2);
    e.op = m_op;
    e.rv = m_rv;
    e.st = 2'(m_st);
    e.disp = (m_st == 2) ? int2bcd(m_n2) : (m_st == 3) ? int2bcd(m_res) : int2bcd(m_n1);
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers: one key or idle cycle per negedge, expectation queued alongside.
  task automatic send_key(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = k;
    model_step(1'b1, k);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      key_code = 4'($urandom_range(0, 15));
      model_step(1'b0, 4'h0);
      exp_q.push_back(snapshot());
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_num1"}, num1_bcd, 16'h0);
    check({tag, "_num2"}, num2_bcd, 16'h0);
    check({tag, "_op"}, {14'h0, operacion}, 16'h0);
    check({tag, "_disp"}, display_bcd, 16'h0);
    check({tag, "_rv"}, {15'h0, result_valid}, 16'h0);
    check({tag, "_estado"}, {14'h0, estado}, 16'h0);
  endtask

  // Monitor: every edge that follows a driven cycle is compared against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sb_num1", num1_bcd, mon_e.n1);
        check("sb_num2", num2_bcd, mon_e.n2);
        check("sb_op", {14'h0, operacion}, {14'h0, mon_e.op});
        check("sb_disp", display_bcd, mon_e.disp);
        check("sb_rv", {15'h0, result_valid}, {15'h0, mon_e.rv});
        check("sb_estado", {14'h0, estado}, {14'h0, mon_e.st});
      end
    end
  end

  initial begin
    int r;
    int budget;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 12 + 34 = 46
    send_key(4'h1); send_key(4'h2); send_key(K_ADD); send_key(4'h3); send_key(4'h4); send_key(K_EQ);
    settle();
    check("t1_num1", num1_bcd, 16'h0012);
    check("t1_num2", num2_bcd, 16'h0034);
    check("t1_op", {14'h0, operacion}, 16'h0001);
    check("t1_disp", display_bcd, 16'h0046);
    check("t1_rv", {15'h0, result_valid}, 16'h0001);
    check("t1_estado", {14'h0, estado}, 16'h0003);
    idle(1);

    // 5 - 9 underflows to 0
    send_key(4'h5); send_key(K_SUB); send_key(4'h9); send_key(K_EQ);
    settle();
    check("t2_disp", display_bcd, 16'h0000);
    check("t2_op", {14'h0, operacion}, 16'h0002);

    // chained operator
    send_key(4'h3); send_key(K_ADD); send_key(4'h4); send_key(K_ADD);
    settle();
    check("t3_num1", num1_bcd, 16'h0007);
    check("t3_disp", display_bcd, 16'h0007);
    check("t3_estado", {14'h0, estado}, 16'h0001);
    send_key(4'h5); send_key(K_EQ);
    settle();
    check("t3_final", display_bcd, 16'h0012);

    // digit limit and backspace
    send_key(K_CLR);
    send_key(4'h1); send_key(4'h2); send_key(4'h3); send_key(4'h4); send_key(4'h5);
    settle();
    check("t4_full", num1_bcd, 16'h1234);
    send_key(K_BS);
    settle();
    check("t4_bs", num1_bcd, 16'h0123);
    send_key(4'h0); send_key(4'h0);
    settle();
    check("t4_held", num1_bcd, 16'h1230);

    // saturation and chaining from result
    send_key(K_CLR);
    send_key(4'h9); send_key(4'h9); send_key(4'h9); send_key(4'h9);
    send_key(K_ADD); send_key(4'h1); send_key(K_EQ);
    settle();
    check("t5_sat", display_bcd, 16'h9999);
    send_key(K_ADD); send_key(4'h1); send_key(K_EQ);
    settle();
    check("t5_chain", display_bcd, 16'h9999);

    // asynchronous reset mid-entry
    send_key(4'h7); send_key(K_ADD); send_key(4'h8);
    @(negedge clk);
    key_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // clear in S_NUM2
    send_key(4'h7); send_key(K_ADD); send_key(4'h8); send_key(K_CLR);
    settle();
    check_zero("clr");
    idle(1);

    // randomized key stream
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      send_key(4'($urandom_range(0, 9)));
      else if (r < 55) send_key(K_ADD);
      else if (r < 63) send_key(K_SUB);
      else if (r < 73) send_key(K_EQ);
      else if (r < 83) send_key(K_BS);
      else if (r < 86) send_key(K_CLR);
      else if (r < 89) send_key(K_BAD);
      else             idle($urandom_range(1, 3));
    end
    idle(2);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
